// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router types and header field positions
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HDR_RD,
    HDR_CAP,
    BODY,
    CHECK
  } state_t;

  localparam int LEN_MSB            = 7;
  localparam int LEN_LSB            = 2;
  localparam int ADDR_MSB           = 1;
  localparam int LEN_W              = LEN_MSB - LEN_LSB + 1;
  localparam int ROUTER_WDOG_CYCLES = 30;

endpackage

// File: rtl/router_port_reader_if.sv
// rtl/router_port_reader_if.sv - router port FIFO and payload sink signal bundle
interface router_port_reader_if;
  import router_pkg::*;

  logic             vld_out;
  logic [7:0]       data_out;
  logic             soft_reset;
  logic             sink_ready;
  logic             read_enb;
  logic [7:0]       pkt_data;
  logic             pkt_valid;
  logic             pkt_sop;
  logic             pkt_eop;
  logic [LEN_W-1:0] pkt_len;
  logic             pkt_done;
  logic             parity_err;
  logic             addr_err;
  logic             pkt_abort;
  logic             stall_warn;

  modport master (
    input  vld_out, data_out, soft_reset, sink_ready,
    output read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_len,
           pkt_done, parity_err, addr_err, pkt_abort, stall_warn
  );

  modport slave (
    output vld_out, data_out, soft_reset, sink_ready,
    input  read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_len,
           pkt_done, parity_err, addr_err, pkt_abort, stall_warn
  );

endinterface

// File: rtl/router_parity_acc.sv
// rtl/router_parity_acc.sv - 8-bit even-XOR parity accumulator with compare
module router_parity_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic       acc_en,
  input  logic [7:0] din,
  output logic       mismatch
);

  logic [7:0] acc_q;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= din;
    end else if (acc_en) begin
      acc_q <= acc_q ^ din;
    end
  end

  assign mismatch = (acc_q != din);

endmodule

// File: rtl/router_port_reader.sv
// rtl/router_port_reader.sv - drains one router output port, parses and checks packets
module router_port_reader
  import router_pkg::*;
#(
  parameter int         RD_DELAY    = 2,
  parameter int         WARN_CYCLES = 24,
  parameter logic [1:0] PORT_ID     = 2'b00
) (
  input logic                  clk,
  input logic                  reset,
  router_port_reader_if.master bus
);

  localparam logic [4:0] RD_LAST = (RD_DELAY == 0) ? 5'd0 : 5'(RD_DELAY - 1);

  state_t           state, state_nxt;
  logic [4:0]       delay_cnt;
  logic             rd_q;
  logic [6:0]       issue_rem, cap_rem;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       addr_q;
  logic             perr_q;
  logic             abort_q;
  logic [7:0]       stall_cnt;
  logic             abort_now, read_req, read_issue;
  logic             body_cap, payload_cap, last_cap, acc_mismatch;
  logic [6:0]       hdr_rem;

  assign abort_now   = bus.soft_reset && (state != IDLE);
  assign read_issue  = read_req && bus.vld_out && !abort_now;
  assign body_cap    = (state == BODY) && rd_q && !abort_now;
  assign payload_cap = body_cap && (cap_rem > 7'd1);
  assign last_cap    = body_cap && (cap_rem == 7'd1);
  assign hdr_rem     = {1'b0, bus.data_out[LEN_MSB:LEN_LSB]} + 7'd1;

  always_comb begin
    read_req = 1'b0;
    case (state)
      HDR_RD:  read_req = 1'b1;
      BODY:    read_req = bus.sink_ready && (issue_rem != 7'd0);
      default: read_req = 1'b0;
    endcase
  end

  // soft_reset outranks every other transition
  always_comb begin
    state_nxt = state;
    if (abort_now) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.vld_out) state_nxt = WAIT;
        WAIT: begin
          if (!bus.vld_out)              state_nxt = IDLE;
          else if (delay_cnt >= RD_LAST) state_nxt = HDR_RD;
        end
        HDR_RD:  if (read_issue) state_nxt = HDR_CAP;
        HDR_CAP: state_nxt = BODY;
        BODY:    if (last_cap) state_nxt = CHECK;
        CHECK:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      delay_cnt <= '0;
      rd_q      <= 1'b0;
      issue_rem <= '0;
      cap_rem   <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      perr_q    <= 1'b0;
      abort_q   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      abort_q   <= abort_now;
      rd_q      <= read_issue;
      delay_cnt <= (state == WAIT && !abort_now) ? delay_cnt + 5'd1 : 5'd0;

      if (abort_now) begin
        issue_rem <= '0;
        cap_rem   <= '0;
        perr_q    <= 1'b0;
      end else if (state == HDR_CAP) begin
        len_q     <= bus.data_out[LEN_MSB:LEN_LSB];
        addr_q    <= bus.data_out[ADDR_MSB:0];
        issue_rem <= hdr_rem;
        cap_rem   <= hdr_rem;
      end else begin
        if (read_issue && state == BODY) issue_rem <= issue_rem - 7'd1;
        if (body_cap)                    cap_rem   <= cap_rem - 7'd1;
        if (last_cap)                    perr_q    <= acc_mismatch;
      end

      if (abort_now || !bus.vld_out || read_issue) begin
        stall_cnt <= '0;
      end else if (state != IDLE && state != WAIT && stall_cnt != 8'hFF) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end

  router_parity_acc u_parity (
    .clk      (clk),
    .reset    (reset),
    .clr      (abort_now),
    .load     (state == HDR_CAP),
    .acc_en   (payload_cap),
    .din      (bus.data_out),
    .mismatch (acc_mismatch)
  );

  assign bus.read_enb   = read_issue;
  assign bus.pkt_valid  = payload_cap;
  assign bus.pkt_data   = payload_cap ? bus.data_out : 8'h00;
  assign bus.pkt_sop    = payload_cap && (cap_rem == ({1'b0, len_q} + 7'd1));
  assign bus.pkt_eop    = payload_cap && (cap_rem == 7'd2);
  assign bus.pkt_len    = len_q;
  assign bus.pkt_done   = (state == CHECK) && !bus.soft_reset;
  assign bus.parity_err = bus.pkt_done && perr_q;
  assign bus.addr_err   = bus.pkt_done && (addr_q != PORT_ID);
  assign bus.pkt_abort  = abort_q;
  assign bus.stall_warn = (stall_cnt >= 8'(WARN_CYCLES));

endmodule

// File: tb/tb_router_port_reader.sv
// tb/tb_router_port_reader.sv - directed self-checking bench for router_port_reader
module tb_router_port_reader;

  logic clk = 1'b0;
  logic reset;

  router_port_reader_if bus ();

  router_port_reader #(
    .RD_DELAY    (2),
    .WARN_CYCLES (24),
    .PORT_ID     (2'b00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] fifo[$];
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  int sop_cnt, eop_cnt, sop_idx, eop_idx, done_cnt, abort_cnt;
  int first_rd_cyc, first_val_cyc, last_val_cyc, abort_cyc, start_cyc;
  logic done_perr, done_aerr, o_rd, o_warn;
  logic [5:0] done_len;
  logic rx_ok;

  task automatic clear_obs();
    rx.delete();
    sop_cnt = 0; eop_cnt = 0; sop_idx = -1; eop_idx = -1;
    done_cnt = 0; abort_cnt = 0;
    first_rd_cyc = -1; first_val_cyc = -1; last_val_cyc = -1; abort_cyc = -1;
    done_perr = 1'b0; done_aerr = 1'b0; done_len = '0;
  endtask

  // One clock: sample outputs at negedge, then model the router FIFO after the edge
  task automatic step();
    @(negedge clk);
    o_rd   = bus.read_enb;
    o_warn = bus.stall_warn;
    if (o_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (bus.pkt_sop) begin sop_cnt++; sop_idx = rx.size(); end
    if (bus.pkt_eop) begin eop_cnt++; eop_idx = rx.size(); end
    if (bus.pkt_valid) begin
      if (first_val_cyc < 0) first_val_cyc = cyc;
      last_val_cyc = cyc;
      rx.push_back(bus.pkt_data);
    end
    if (bus.pkt_done) begin
      done_cnt++;
      done_perr = bus.parity_err;
      done_aerr = bus.addr_err;
      done_len  = bus.pkt_len;
    end
    if (bus.pkt_abort) begin abort_cnt++; abort_cyc = cyc; end
    @(posedge clk);
    #1;
    if (o_rd && fifo.size() != 0) bus.data_out = fifo.pop_front();
    bus.vld_out = (fifo.size() != 0);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.vld_out = 1'b0; bus.data_out = 8'h00;
    bus.soft_reset = 1'b0; bus.sink_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.vld_out = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.read_enb, bus.pkt_data, bus.pkt_valid, bus.pkt_sop, bus.pkt_eop, bus.pkt_len,
         bus.pkt_done, bus.parity_err, bus.addr_err, bus.pkt_abort, bus.stall_warn} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got read_enb=%b valid=%b len=%0d done=%b warn=%b required all 0",
               bus.read_enb, bus.pkt_valid, bus.pkt_len, bus.pkt_done, bus.stall_warn);
    end
    @(posedge clk);
    #1 bus.vld_out = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    clear_obs();
    start_cyc = cyc;
    fifo = '{8'h0C, 8'hA1, 8'hB2, 8'hC3, 8'hDC};
    bus.vld_out = 1'b1;
    for (int i = 0; i < 40 && done_cnt == 0; i++) step();
    step(); step();
    checks++;
    if (first_rd_cyc - start_cyc != 3) begin
      failures++; $display("FAIL basic_rd_delay got=%0d required=3", first_rd_cyc - start_cyc);
    end
    checks++;
    if (first_val_cyc - first_rd_cyc != 3) begin
      failures++; $display("FAIL basic_first_valid_latency got=%0d required=3", first_val_cyc - first_rd_cyc);
    end
    checks++;
    if (last_val_cyc - first_val_cyc != 2) begin
      failures++; $display("FAIL basic_full_rate got=%0d required=2", last_val_cyc - first_val_cyc);
    end
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    rx_ok = (rx.size() == exp_q.size());
    for (int i = 0; i < rx.size() && rx_ok; i++) if (rx[i] !== exp_q[i]) rx_ok = 1'b0;
    checks++;
    if (!rx_ok) begin
      failures++; $display("FAIL basic_payload got %0d bytes required A1 B2 C3", rx.size());
    end
    checks++;
    if (sop_cnt != 1 || sop_idx != 0 || eop_cnt != 1 || eop_idx != 2) begin
      failures++; $display("FAIL basic_sop_eop got sop=%0d@%0d eop=%0d@%0d required 1@0 1@2",
                           sop_cnt, sop_idx, eop_cnt, eop_idx);
    end
    checks++;
    if (done_cnt != 1 || done_perr !== 1'b0 || done_aerr !== 1'b0 || done_len !== 6'd3) begin
      failures++; $display("FAIL basic_done got done=%0d perr=%b aerr=%b len=%0d required 1 0 0 3",
                           done_cnt, done_perr, done_aerr, done_len);
    end
  endtask

  task automatic test_parity_err();
    clear_obs();
    fifo = '{8'h0C, 8'hA1, 8'hB2, 8'hC3, 8'h00};
    bus.vld_out = 1'b1;
    for (int i = 0; i < 40 && done_cnt == 0; i++) step();
    step();
    checks++;
    if (done_cnt != 1 || done_perr !== 1'b1 || done_aerr !== 1'b0) begin
      failures++; $display("FAIL parity_err_flag got done=%0d perr=%b aerr=%b required 1 1 0",
                           done_cnt, done_perr, done_aerr);
    end
    checks++;
    if (rx.size() != 3 || rx[2] !== 8'hC3) begin
      failures++; $display("FAIL parity_err_payload got %0d bytes required 3 ending C3", rx.size());
    end
  endtask

  task automatic test_len0();
    clear_obs();
    fifo = '{8'h01, 8'h01};
    bus.vld_out = 1'b1;
    for (int i = 0; i < 40 && done_cnt == 0; i++) step();
    step();
    checks++;
    if (rx.size() != 0 || sop_cnt != 0 || eop_cnt != 0) begin
      failures++; $display("FAIL len0_no_payload got valid=%0d sop=%0d eop=%0d required 0 0 0",
                           rx.size(), sop_cnt, eop_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_perr !== 1'b0 || done_aerr !== 1'b1 || done_len !== 6'd0) begin
      failures++; $display("FAIL len0_done got done=%0d perr=%b aerr=%b len=%0d required 1 0 1 0",
                           done_cnt, done_perr, done_aerr, done_len);
    end
  endtask

  task automatic test_stall();
    int rd_hold;
    int warn_idx;
    clear_obs();
    fifo = '{8'h14, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h05};
    bus.vld_out = 1'b1;
    for (int i = 0; i < 20 && rx.size() == 0; i++) step();
    bus.sink_ready = 1'b0;
    rd_hold = 0;
    warn_idx = -1;
    for (int i = 0; i < 29; i++) begin
      step();
      if (o_rd) rd_hold++;
      if (o_warn && warn_idx < 0) warn_idx = i;
    end
    checks++;
    if (rx.size() != 2) begin
      failures++; $display("FAIL stall_trailing_byte got=%0d required=2", rx.size());
    end
    bus.sink_ready = 1'b1;
    for (int i = 0; i < 40 && done_cnt == 0; i++) step();
    step(); step();
    checks++;
    if (rd_hold != 0) begin
      failures++; $display("FAIL stall_read_during_hold got=%0d required=0", rd_hold);
    end
    checks++;
    if (warn_idx != 24) begin
      failures++; $display("FAIL stall_warn_rise got=%0d required=24", warn_idx);
    end
    checks++;
    if (o_warn !== 1'b0) begin
      failures++; $display("FAIL stall_warn_clear got=%b required=0", o_warn);
    end
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rx_ok = (rx.size() == exp_q.size());
    for (int i = 0; i < rx.size() && rx_ok; i++) if (rx[i] !== exp_q[i]) rx_ok = 1'b0;
    checks++;
    if (!rx_ok || done_cnt != 1 || done_perr !== 1'b0 || done_len !== 6'd5) begin
      failures++; $display("FAIL stall_complete got bytes=%0d done=%0d perr=%b len=%0d required 5 1 0 5",
                           rx.size(), done_cnt, done_perr, done_len);
    end
  endtask

  task automatic test_abort();
    int sr_cyc;
    clear_obs();
    bus.soft_reset = 1'b1;
    step();
    bus.soft_reset = 1'b0;
    step(); step();
    checks++;
    if (abort_cnt != 0) begin
      failures++; $display("FAIL abort_idle_ignored got=%0d required=0", abort_cnt);
    end
    fifo = '{8'h0C, 8'hA1, 8'hB2, 8'hC3, 8'hDC};
    bus.vld_out = 1'b1;
    for (int i = 0; i < 20 && rx.size() < 2; i++) step();
    bus.soft_reset = 1'b1;
    sr_cyc = cyc;
    step();
    bus.soft_reset = 1'b0;
    fifo.delete();
    bus.vld_out = 1'b0;
    repeat (5) step();
    checks++;
    if (abort_cnt != 1 || abort_cyc != sr_cyc + 1) begin
      failures++; $display("FAIL abort_pulse got count=%0d delay=%0d required 1 1",
                           abort_cnt, abort_cyc - sr_cyc);
    end
    checks++;
    if (done_cnt != 0 || rx.size() != 2) begin
      failures++; $display("FAIL abort_no_done got done=%0d bytes=%0d required 0 2", done_cnt, rx.size());
    end
    clear_obs();
    fifo = '{8'h08, 8'h5A, 8'hA5, 8'hF7};
    bus.vld_out = 1'b1;
    for (int i = 0; i < 40 && done_cnt == 0; i++) step();
    step();
    checks++;
    if (rx.size() != 2 || rx[0] !== 8'h5A || rx[1] !== 8'hA5 || done_cnt != 1 ||
        done_perr !== 1'b0 || done_aerr !== 1'b0 || done_len !== 6'd2) begin
      failures++; $display("FAIL abort_next_pkt got bytes=%0d done=%0d perr=%b len=%0d required 2 1 0 2",
                           rx.size(), done_cnt, done_perr, done_len);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    fifo = '{8'h0C, 8'hA1, 8'hB2, 8'hC3, 8'hDC};
    bus.vld_out = 1'b1;
    for (int i = 0; i < 20 && rx.size() == 0; i++) step();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.read_enb, bus.pkt_data, bus.pkt_valid, bus.pkt_sop, bus.pkt_eop, bus.pkt_len,
         bus.pkt_done, bus.parity_err, bus.addr_err, bus.pkt_abort, bus.stall_warn} !== 23'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got read_enb=%b valid=%b len=%0d done=%b abort=%b required all 0",
               bus.read_enb, bus.pkt_valid, bus.pkt_len, bus.pkt_done, bus.pkt_abort);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_obs();
    start_cyc = cyc;
    fifo = '{8'h0C, 8'hA1, 8'hB2, 8'hC3, 8'hDC};
    bus.vld_out = 1'b1;
    for (int i = 0; i < 40 && done_cnt == 0; i++) step();
    step();
    checks++;
    if (first_rd_cyc - start_cyc != 3) begin
      failures++; $display("FAIL reset_mid_restart got=%0d required=3", first_rd_cyc - start_cyc);
    end
    checks++;
    if (rx.size() != 3 || rx[0] !== 8'hA1 || done_cnt != 1 || done_perr !== 1'b0 || abort_cnt != 0) begin
      failures++; $display("FAIL reset_mid_pkt got bytes=%0d done=%0d perr=%b abort=%0d required 3 1 0 0",
                           rx.size(), done_cnt, done_perr, abort_cnt);
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_basic();
    test_parity_err();
    test_len0();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
